// File: rtl/demux_32to4_buf.sv
// Buffered 1-to-4 demultiplexer: one valid/ready input stream is steered by sel
// into four independent per-channel FIFOs, each with its own valid/ready output.
module demux_32to4_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic             busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem   [4][DEPTH];
    logic [PW-1:0]    r_wptr  [4];
    logic [PW-1:0]    r_rptr  [4];
    logic [CW-1:0]    r_count [4];

    logic [3:0]       w_push;
    logic [3:0]       w_pop;
    logic [WIDTH-1:0] w_head  [4];

    // Pointers wrap modulo DEPTH, which need not fill the pointer width.
    function automatic logic [PW-1:0] ptrInc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Readiness looks only at the selected channel's fill level, never at out_ready.
    assign in_ready = en & ~rst & (r_count[sel] != FULL);

    always_comb begin
        w_push    = '0;
        out_valid = '0;
        w_head    = '{default: '0};
        for (int k = 0; k < 4; k++) begin
            out_valid[k] = (r_count[k] != '0);
            w_head[k]    = out_valid[k] ? r_mem[k][r_rptr[k]] : '0;
        end
        w_pop = out_valid & out_ready;
        if (in_valid && in_ready) begin
            w_push[sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                r_wptr[k]  <= '0;
                r_rptr[k]  <= '0;
                r_count[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_push[k]) begin
                    r_wptr[k] <= ptrInc(r_wptr[k]);
                end
                if (w_pop[k]) begin
                    r_rptr[k] <= ptrInc(r_rptr[k]);
                end
                case ({w_push[k], w_pop[k]})
                    2'b10:   r_count[k] <= r_count[k] + 1'b1;
                    2'b01:   r_count[k] <= r_count[k] - 1'b1;
                    default: r_count[k] <= r_count[k];
                endcase
            end
        end
    end

    // Storage needs no reset: a slot is only ever read after it has been written.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (w_push[k]) begin
                r_mem[k][r_wptr[k]] <= in_data;
            end
        end
    end

    assign out1 = w_head[0];
    assign out2 = w_head[1];
    assign out3 = w_head[2];
    assign out4 = w_head[3];
    assign busy = |out_valid;

endmodule

// File: tb/tb_demux_32to4_buf.sv
// Scoreboard bench for demux_32to4_buf: per-channel expected queues filled by the
// stimulus, drained and compared by an independent monitor.
module tb_demux_32to4_buf;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  sel = 2'b00;
    logic [31:0] inData = '0;
    logic        inValid = 1'b0;
    logic        inReady;
    logic [31:0] out1, out2, out3, out4;
    logic [3:0]  outValid;
    logic [3:0]  outReady = 4'b0000;
    logic        busy;

    logic [31:0] expQ [4][$];
    logic [31:0] outArr [4];
    int          total = 0;
    int          bad = 0;
    bit          armed = 1'b0;

    demux_32to4_buf #(.WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en(en), .sel(sel),
        .in_data(inData), .in_valid(inValid), .in_ready(inReady),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4),
        .out_valid(outValid), .out_ready(outReady), .busy(busy)
    );

    always #5 clk = ~clk;

    assign outArr[0] = out1;
    assign outArr[1] = out2;
    assign outArr[2] = out3;
    assign outArr[3] = out4;

    // Shared comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // One cycle: drive inputs, check in_ready against queue occupancy, then record the outcome.
    task automatic applyStimulus(input bit r, input bit e, input logic [1:0] s,
                                 input logic [31:0] d, input bit v, input logic [3:0] rdy);
        bit expReady;
        bit accept;
        @(negedge clk);
        rst = r; en = e; sel = s; inData = d; inValid = v; outReady = rdy;
        #1;
        expReady = e && !r && (expQ[s].size() < DEPTH);
        if (armed) checkOutput("in_ready", {31'b0, inReady}, {31'b0, expReady});
        accept = v && expReady;
        @(posedge clk);
        #1;
        if (r) begin
            for (int k = 0; k < 4; k++) expQ[k].delete();
        end else if (accept) begin
            expQ[s].push_back(d);
        end
    endtask

    // Monitor: compares every channel head against its queue, then retires words the consumer takes.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (armed) begin
                logic [3:0] expValid;
                for (int k = 0; k < 4; k++) begin
                    expValid[k] = (expQ[k].size() != 0);
                    checkOutput($sformatf("out_valid[%0d]", k), {31'b0, outValid[k]}, {31'b0, expValid[k]});
                    checkOutput($sformatf("out%0d", k + 1), outArr[k], expValid[k] ? expQ[k][0] : 32'h0);
                end
                checkOutput("busy", {31'b0, busy}, {31'b0, |expValid});
                for (int k = 0; k < 4; k++) begin
                    if (outReady[k] && expValid[k]) void'(expQ[k].pop_front());
                end
            end
        end
    end

    initial begin
        // Reset, then idle with enable high.
        applyStimulus(1, 1, 2'd0, 32'h0, 0, 4'b0000);
        applyStimulus(1, 1, 2'd0, 32'h0, 0, 4'b0000);
        armed = 1'b1;
        applyStimulus(0, 1, 2'd0, 32'h0, 0, 4'b0000);

        // Routing to each channel.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 1, 2'(k), 32'hAAAA0001 + 32'(k), 1, 4'b0000);
        end
        applyStimulus(0, 1, 2'd0, 32'h0, 0, 4'b0000);

        // Fill channel 3, hit backpressure, then drain it.
        applyStimulus(0, 1, 2'd3, 32'h0, 0, 4'b1000);
        applyStimulus(0, 1, 2'd2, 32'h11, 1, 4'b0000);
        applyStimulus(0, 1, 2'd2, 32'h22, 1, 4'b0000);
        applyStimulus(0, 1, 2'd2, 32'h33, 1, 4'b0000);
        applyStimulus(0, 1, 2'd0, 32'h0, 0, 4'b0000);
        applyStimulus(0, 1, 2'd2, 32'h0, 0, 4'b0100);
        applyStimulus(0, 1, 2'd2, 32'h0, 0, 4'b0100);
        applyStimulus(0, 1, 2'd2, 32'h0, 0, 4'b0100);

        // Simultaneous push and pop on channel 1.
        applyStimulus(0, 1, 2'd0, 32'h0, 0, 4'b0001);
        applyStimulus(0, 1, 2'd0, 32'h5, 1, 4'b0000);
        applyStimulus(0, 1, 2'd0, 32'h6, 1, 4'b0001);
        applyStimulus(0, 1, 2'd0, 32'h0, 0, 4'b0000);

        // Enable gating while channel 4 still drains.
        applyStimulus(0, 1, 2'd0, 32'h0, 0, 4'b1111);
        applyStimulus(0, 1, 2'd3, 32'hDEAD, 1, 4'b0000);
        applyStimulus(0, 0, 2'd3, 32'hBEEF, 1, 4'b0000);
        applyStimulus(0, 0, 2'd3, 32'hBEEF, 1, 4'b1000);
        applyStimulus(0, 0, 2'd1, 32'hBEEF, 1, 4'b0000);

        // Mid-operation reset discards buffered words.
        applyStimulus(0, 1, 2'd1, 32'h21, 1, 4'b0000);
        applyStimulus(0, 1, 2'd2, 32'h31, 1, 4'b0000);
        applyStimulus(0, 1, 2'd1, 32'h22, 1, 4'b0000);
        applyStimulus(1, 1, 2'd1, 32'h99, 1, 4'b1111);
        applyStimulus(0, 1, 2'd1, 32'h77, 1, 4'b0000);
        applyStimulus(0, 1, 2'd0, 32'h0, 0, 4'b0000);

        // Randomized traffic with occasional reset and enable drops.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 60) == 0), ($urandom_range(0, 7) != 0),
                          2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 3) != 0),
                          4'($urandom_range(0, 15)));
        end

        // Drain so every buffered word is checked.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 2'd0, 32'h0, 0, 4'b1111);
        end
        applyStimulus(0, 1, 2'd0, 32'h0, 0, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
